// File: rtl/ysyx_23060184_lsu_ctrl.sv
//----------------------------------------------------------------------------
// Module  : ysyx_23060184_lsu_ctrl
// Brief   : Load/store unit controller between execute and writeback.
//           Issues one word-aligned memory request per load/store, forms
//           byte strobes and replicated store data, and extends load data.
//           Optional macro YSYX_23060184_LSU_MISALIGN_EN enables trapping of
//           misaligned halfword/word accesses (reported on misalign_err).
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module ysyx_23060184_lsu_ctrl (
  input  logic        clk,
  input  logic        rstn,
  // execute-side handshake
  input  logic        Evalid,
  output logic        Mready,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  Funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  // writeback-side handshake
  output logic        Mvalid,
  input  logic        Wready,
  output logic [31:0] ReadData,
  output logic        misalign_err,
  // memory request / response
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q;
  logic        mready_q;
  logic        mvalid_q;
  logic        req_valid_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rdata_q;
  logic        misalign_q;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic [3:0]  strb_d;
  logic [31:0] wdata_d;
  logic [7:0]  byte_d;
  logic [15:0] half_d;
  logic [31:0] load_d;
  logic        misalign_d;

  // Store lane strobes and replicated store data from the incoming access
  always_comb begin
    strb_d  = 4'b1111;
    wdata_d = WriteData;
    case (Funct3[1:0])
      2'b00: begin
        strb_d  = 4'b0001 << ALUResult[1:0];
        wdata_d = {4{WriteData[7:0]}};
      end
      2'b01: begin
        strb_d  = 4'b0011 << {ALUResult[1], 1'b0};
        wdata_d = {2{WriteData[15:0]}};
      end
      default: begin
        strb_d  = 4'b1111;
        wdata_d = WriteData;
      end
    endcase
  end

  // Extract and extend the addressed byte/half from the response word
  always_comb begin
    byte_d = mem_rdata[{off_q, 3'b000} +: 8];
    half_d = mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (funct3_q)
      3'b000:  load_d = {{24{byte_d[7]}}, byte_d};
      3'b001:  load_d = {{16{half_d[15]}}, half_d};
      3'b100:  load_d = {24'd0, byte_d};
      3'b101:  load_d = {16'd0, half_d};
      default: load_d = mem_rdata;
    endcase
  end

`ifdef YSYX_23060184_LSU_MISALIGN_EN
  // Misaligned halfword (odd address) or word (not 4-aligned) memory access
  assign misalign_d = (MemRead | MemWrite) &&
                      (((Funct3[1:0] == 2'b01) && ALUResult[0]) ||
                       ((Funct3[1:0] == 2'b10) && (ALUResult[1:0] != 2'b00)));
`else
  assign misalign_d = 1'b0;
`endif

  // Control FSM with all interface outputs registered
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      mready_q    <= 1'b1;
      mvalid_q    <= 1'b0;
      req_valid_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      wstrb_q     <= 4'd0;
      rdata_q     <= 32'd0;
      misalign_q  <= 1'b0;
      load_q      <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (Evalid) begin
            mready_q <= 1'b0;
            funct3_q <= Funct3;
            off_q    <= ALUResult[1:0];
            load_q   <= MemRead & ~MemWrite;
            addr_q   <= {ALUResult[31:2], 2'b00};
            wdata_q  <= wdata_d;
            if (misalign_d) begin
              state_q    <= S_HOLD;
              mvalid_q   <= 1'b1;
              misalign_q <= 1'b1;
              rdata_q    <= 32'd0;
            end else if (MemRead | MemWrite) begin
              state_q     <= S_REQ;
              req_valid_q <= 1'b1;
              we_q        <= MemWrite;
              wstrb_q     <= MemWrite ? strb_d : 4'd0;
            end else begin
              state_q  <= S_HOLD;
              mvalid_q <= 1'b1;
              rdata_q  <= 32'd0;
            end
          end
        end
        S_REQ: begin
          // A response coinciding with the accept is not consumed here
          if (mem_req_ready) begin
            state_q     <= S_RESP;
            req_valid_q <= 1'b0;
            we_q        <= 1'b0;
            wstrb_q     <= 4'd0;
          end
        end
        S_RESP: begin
          if (mem_rsp_valid) begin
            state_q  <= S_HOLD;
            mvalid_q <= 1'b1;
            rdata_q  <= load_q ? load_d : 32'd0;
          end
        end
        S_HOLD: begin
          if (Wready) begin
            state_q    <= S_IDLE;
            mvalid_q   <= 1'b0;
            mready_q   <= 1'b1;
            misalign_q <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Mready        = mready_q;
  assign Mvalid        = mvalid_q;
  assign ReadData      = rdata_q;
  assign misalign_err  = misalign_q;
  assign mem_req_valid = req_valid_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_wstrb     = wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_23060184_lsu_ctrl.sv
//----------------------------------------------------------------------------
// Module  : tb_ysyx_23060184_lsu_ctrl
// Brief   : Self-checking bench for ysyx_23060184_lsu_ctrl: vector table of
//           loads/stores/pass-through plus multi-cycle corner sequences.
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ysyx_23060184_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        Evalid = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] ALUResult = 32'd0;
  logic [31:0] WriteData = 32'd0;
  logic        Wready = 1'b0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;

  logic        Mready, Mvalid, misalign_err, mem_req_valid, mem_we;
  logic [31:0] ReadData, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  always #5 clk = ~clk;

  ysyx_23060184_lsu_ctrl dut (
    .clk           (clk),
    .rstn          (rstn),
    .Evalid        (Evalid),
    .Mready        (Mready),
    .MemRead       (MemRead),
    .MemWrite      (MemWrite),
    .Funct3        (Funct3),
    .ALUResult     (ALUResult),
    .WriteData     (WriteData),
    .Mvalid        (Mvalid),
    .Wready        (Wready),
    .ReadData      (ReadData),
    .misalign_err  (misalign_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rdata     (mem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;      // word the memory model returns
    logic        exp_req;    // a memory request is expected
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [3:0]  exp_strb;   // checked for stores only
    logic [31:0] exp_wdata;  // checked for stores only
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } res_t;

  localparam int NVEC = 13;
  vec_t vt [NVEC];
  res_t sb_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mready"},   32'(Mready),        32'd1);
    chk({tag, "_mvalid"},   32'(Mvalid),        32'd0);
    chk({tag, "_reqvalid"}, 32'(mem_req_valid), 32'd0);
    chk({tag, "_we"},       32'(mem_we),        32'd0);
    chk({tag, "_wstrb"},    32'(mem_wstrb),     32'd0);
    chk({tag, "_readdata"}, ReadData,           32'd0);
    chk({tag, "_err"},      32'(misalign_err),  32'd0);
  endtask

  // One complete transaction with a reactive memory and writeback model
  task automatic run_txn(input vec_t v, input int rdy_dly, input int rsp_dly,
                         input int wr_dly, input bit early_rsp);
    int t, req_cnt, rsp_cnt, hold_cnt, exp_lat;
    bit hs_req, rsp_sent, wb;
    logic [31:0] a0, d0, rd0;
    logic [4:0]  c0;
    res_t e, r;
    t = 0;
    while (!Mready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("mready_before_issue", 32'(Mready), 32'd1);
    Evalid    = 1'b1;
    MemRead   = v.rd;
    MemWrite  = v.wr;
    Funct3    = v.f3;
    ALUResult = v.addr;
    WriteData = v.wdata;
    e.rd  = v.exp_rd;
    e.err = v.exp_err;
    sb_q.push_back(e);
    exp_lat = v.exp_req ? (3 + rdy_dly + rsp_dly) : 1;
    @(posedge clk);
    #1;
    Evalid   = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    req_cnt = 0; rsp_cnt = 0; hold_cnt = 0;
    hs_req = 1'b0; rsp_sent = 1'b0; wb = 1'b0;
    a0 = '0; d0 = '0; c0 = '0; rd0 = '0;
    for (int c = 1; c <= 60 && !wb; c++) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      mem_rdata     = 32'hA5C3_0F96;
      Wready        = 1'b0;
      if (hs_req) begin
        chk("req_valid_after_accept", 32'(mem_req_valid), 32'd0);
        if (!rsp_sent) begin
          rsp_cnt++;
          if (rsp_cnt > rsp_dly) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = v.rdata;
            rsp_sent      = 1'b1;
          end
        end
      end else if (!v.exp_req) begin
        chk("no_req_valid", 32'(mem_req_valid), 32'd0);
      end else if (mem_req_valid) begin
        req_cnt++;
        if (req_cnt == 1) begin
          chk("req_addr", mem_addr, v.exp_addr);
          chk("req_we", 32'(mem_we), 32'(v.exp_we));
          if (v.wr) begin
            chk("req_wstrb", 32'(mem_wstrb), 32'(v.exp_strb));
            chk("req_wdata", mem_wdata, v.exp_wdata);
          end
          a0 = mem_addr; d0 = mem_wdata; c0 = {mem_we, mem_wstrb};
        end else begin
          chk("req_addr_stable", mem_addr, a0);
          chk("req_wdata_stable", mem_wdata, d0);
          chk("req_ctl_stable", 32'({mem_we, mem_wstrb}), 32'(c0));
        end
        if (req_cnt > rdy_dly) begin
          mem_req_ready = 1'b1;
          hs_req        = 1'b1;
          if (early_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = 32'h5A5A_5A5A;
          end
        end
      end
      if (Mvalid) begin
        if (hold_cnt == 0) begin
          chk("mvalid_latency", 32'(c), 32'(exp_lat));
          rd0 = ReadData;
        end else begin
          chk("readdata_stable", ReadData, rd0);
        end
        chk("mready_low_in_hold", 32'(Mready), 32'd0);
        if (hold_cnt >= wr_dly) begin
          Wready = 1'b1;
          wb     = 1'b1;
          r.rd   = ReadData;
          r.err  = misalign_err;
          if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL writeback_unexpected: got Mvalid=1, expected no pending result");
          end else begin
            e = sb_q.pop_front();
            chk("readdata", r.rd, e.rd);
            chk("misalign_err", 32'(r.err), 32'(e.err));
          end
        end
        hold_cnt++;
      end
    end
    if (!wb) begin
      n_cmp++; n_err++;
      $display("FAIL txn_timeout: got no writeback, expected one within 60 cycles");
      sb_q.delete();
    end
    @(negedge clk);
    Wready = 1'b0;
    chk("mvalid_single_beat", 32'(Mvalid), 32'd0);
    chk("mready_after_wb", 32'(Mready), 32'd1);
  endtask

  initial begin
    //         rd    wr    f3      addr          wdata         rdata         req   exp_addr      we    strb     exp_wdata     exp_rd        err
    vt[0]  = '{1'b1, 1'b0, 3'b000, 32'h8000_0003, 32'h0,        32'h8011_2233, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_FF80, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 3'b100, 32'h8000_0003, 32'h0,        32'h8011_2233, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_0080, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 3'b001, 32'h8000_0002, 32'h0,        32'h8011_2233, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_8011, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 3'b101, 32'h8000_0000, 32'h0,        32'h8011_A233, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h0000_A233, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 3'b010, 32'h8000_0004, 32'h0,        32'hDEAD_BEEF, 1'b1, 32'h8000_0004, 1'b0, 4'b0000, 32'h0,        32'hDEAD_BEEF, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0010, 32'h0,        32'h8011_2233, 1'b1, 32'h0000_0010, 1'b0, 4'b0000, 32'h0,        32'h0000_0033, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 3'b000, 32'h0000_0011, 32'h0,        32'h8011_2233, 1'b1, 32'h0000_0010, 1'b0, 4'b0000, 32'h0,        32'h0000_0022, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 32'h0,        1'b1, 32'h8000_0000, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0,        1'b0};
    vt[8]  = '{1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h1234_56A5, 32'h0,        1'b1, 32'h8000_0000, 1'b1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        1'b0};
    vt[9]  = '{1'b0, 1'b1, 3'b010, 32'h8000_0008, 32'hCAFE_F00D, 32'h0,        1'b1, 32'h8000_0008, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0,        1'b0};
    vt[10] = '{1'b0, 1'b0, 3'b010, 32'h1234_5678, 32'h9999_9999, 32'h0,        1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b0};
`ifdef YSYX_23060184_LSU_MISALIGN_EN
    vt[11] = '{1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'h1122_3344, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
    vt[12] = '{1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0,        32'h8011_2233, 1'b0, 32'h0,        1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
`else
    vt[11] = '{1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0,        32'h1122_3344, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'h1122_3344, 1'b0};
    vt[12] = '{1'b1, 1'b0, 3'b001, 32'h8000_0001, 32'h0,        32'h8011_A233, 1'b1, 32'h8000_0000, 1'b0, 4'b0000, 32'h0,        32'hFFFF_A233, 1'b0};
`endif

    // reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // vector table with modest handshake variation
    for (int i = 0; i < NVEC; i++) begin
      run_txn(vt[i], i % 2, 0, i % 3, 1'b0);
    end

    // slow memory and stalled writeback on a store
    run_txn(vt[7], 3, 2, 2, 1'b0);
    // response presented together with request accept must be ignored
    run_txn(vt[4], 1, 2, 0, 1'b1);
    // back-to-back pass-through with immediate writeback
    run_txn(vt[10], 0, 0, 0, 1'b0);

    // reset abort while waiting for a response, then a stale response
    @(negedge clk);
    Evalid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0;
    Funct3 = 3'b010; ALUResult = 32'h8000_0004;
    @(posedge clk);
    #1;
    Evalid = 1'b0; MemRead = 1'b0;
    @(negedge clk);
    chk("abort_req_valid", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk_reset_outputs("abort");
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'h1234_5678;
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk_reset_outputs("stale_rsp");
      @(negedge clk);
    end

    // recovery after the abort
    run_txn(vt[0], 0, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  // absolute watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200us");
    n_err++;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $fatal(1);
  end

endmodule

`default_nettype wire
